// File: rtl/icb_arb2_pkg.sv
// Shared ICB width defaults and master-select helpers used by the two-master arbiter.
package icb_arb2_pkg;

  localparam int ICB_AW = 32;
  localparam int ICB_DW = 64;
  localparam int ICB_MW = ICB_DW / 8;

  typedef enum logic {
    MST_M0 = 1'b0,
    MST_M1 = 1'b1
  } icb_mst_e;

  // Round-robin pick: a lone requester wins; a tie goes to the master not granted last.
  function automatic icb_mst_e rr_pick(input logic v0, input logic v1, input icb_mst_e last);
    icb_mst_e pick;
    pick = MST_M0;
    if (v0 && v1)  pick = (last == MST_M1) ? MST_M0 : MST_M1;
    else if (v1)   pick = MST_M1;
    return pick;
  endfunction

endpackage

// File: rtl/icb_arb_idfifo.sv
// 1-bit source-ID FIFO tracking outstanding ICB commands in issue order.
module icb_arb_idfifo
  import icb_arb2_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push_i,
  input  logic push_id_i,
  input  logic pop_i,
  output logic head_o,
  output logic full_o,
  output logic empty_o
);

  localparam int PW = $clog2(DEPTH);

  logic [DEPTH-1:0] mem_q;
  logic [PW:0]      wptr_q, wptr_d;
  logic [PW:0]      rptr_q, rptr_d;
  logic             push_en, pop_en;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
  assign head_o  = mem_q[rptr_q[PW-1:0]];

  // No bypass: a full FIFO refuses a push even when a pop lands in the same cycle.
  assign push_en = push_i && !full_o;
  assign pop_en  = pop_i && !empty_o;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push_en) wptr_d = wptr_q + 1'b1;
    if (pop_en)  rptr_d = rptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_en) mem_q[wptr_q[PW-1:0]] <= push_id_i;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

endmodule

// File: rtl/icb_arb2.sv
// Two-master ICB arbiter: round-robin grant with lock, combinational command/response muxes.
module icb_arb2
  import icb_arb2_pkg::*;
#(
  parameter int AW         = ICB_AW,
  parameter int DW         = ICB_DW,
  parameter int MW         = ICB_MW,
  parameter int OUTS_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,

  input  logic          m0_icb_cmd_valid,
  output logic          m0_icb_cmd_ready,
  input  logic          m0_icb_cmd_read,
  input  logic [AW-1:0] m0_icb_cmd_addr,
  input  logic [DW-1:0] m0_icb_cmd_wdata,
  input  logic [MW-1:0] m0_icb_cmd_wmask,
  output logic          m0_icb_rsp_valid,
  input  logic          m0_icb_rsp_ready,
  output logic          m0_icb_rsp_err,
  output logic [DW-1:0] m0_icb_rsp_rdata,

  input  logic          m1_icb_cmd_valid,
  output logic          m1_icb_cmd_ready,
  input  logic          m1_icb_cmd_read,
  input  logic [AW-1:0] m1_icb_cmd_addr,
  input  logic [DW-1:0] m1_icb_cmd_wdata,
  input  logic [MW-1:0] m1_icb_cmd_wmask,
  output logic          m1_icb_rsp_valid,
  input  logic          m1_icb_rsp_ready,
  output logic          m1_icb_rsp_err,
  output logic [DW-1:0] m1_icb_rsp_rdata,

  output logic          o_icb_cmd_valid,
  input  logic          o_icb_cmd_ready,
  output logic          o_icb_cmd_read,
  output logic [AW-1:0] o_icb_cmd_addr,
  output logic [DW-1:0] o_icb_cmd_wdata,
  output logic [MW-1:0] o_icb_cmd_wmask,
  input  logic          o_icb_rsp_valid,
  output logic          o_icb_rsp_ready,
  input  logic          o_icb_rsp_err,
  input  logic [DW-1:0] o_icb_rsp_rdata
);

  icb_mst_e last_q, last_d;
  icb_mst_e lgnt_q, lgnt_d;
  logic     lock_q, lock_d;
  icb_mst_e gnt;
  logic     gvld, cmd_hs, rsp_hs;
  logic     fifo_full, fifo_empty, fifo_head;
  icb_mst_e head;

  always_comb begin
    gnt = rr_pick(m0_icb_cmd_valid, m1_icb_cmd_valid, last_q);
    if (lock_q) gnt = lgnt_q;
  end

  assign gvld = (gnt == MST_M1) ? m1_icb_cmd_valid : m0_icb_cmd_valid;

  // Outputs are forced idle while reset is held so nothing leaks to either side.
  assign o_icb_cmd_valid  = rst && gvld && !fifo_full;
  assign m0_icb_cmd_ready = rst && !fifo_full && o_icb_cmd_ready && (gnt == MST_M0);
  assign m1_icb_cmd_ready = rst && !fifo_full && o_icb_cmd_ready && (gnt == MST_M1);

  assign o_icb_cmd_read  = (gnt == MST_M1) ? m1_icb_cmd_read  : m0_icb_cmd_read;
  assign o_icb_cmd_addr  = (gnt == MST_M1) ? m1_icb_cmd_addr  : m0_icb_cmd_addr;
  assign o_icb_cmd_wdata = (gnt == MST_M1) ? m1_icb_cmd_wdata : m0_icb_cmd_wdata;
  assign o_icb_cmd_wmask = (gnt == MST_M1) ? m1_icb_cmd_wmask : m0_icb_cmd_wmask;

  assign cmd_hs = o_icb_cmd_valid && o_icb_cmd_ready;

  // Lock tracks "command offered but not taken"; a handshake releases it.
  always_comb begin
    last_d = last_q;
    lgnt_d = gnt;
    lock_d = o_icb_cmd_valid && !o_icb_cmd_ready;
    if (cmd_hs) last_d = gnt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q <= MST_M1;
      lgnt_q <= MST_M0;
      lock_q <= 1'b0;
    end else begin
      last_q <= last_d;
      lgnt_q <= lgnt_d;
      lock_q <= lock_d;
    end
  end

  assign head = icb_mst_e'(fifo_head);

  assign o_icb_rsp_ready  = rst && !fifo_empty &&
                            ((head == MST_M1) ? m1_icb_rsp_ready : m0_icb_rsp_ready);
  assign m0_icb_rsp_valid = rst && !fifo_empty && o_icb_rsp_valid && (head == MST_M0);
  assign m1_icb_rsp_valid = rst && !fifo_empty && o_icb_rsp_valid && (head == MST_M1);
  assign m0_icb_rsp_err   = (head == MST_M0) && o_icb_rsp_err;
  assign m1_icb_rsp_err   = (head == MST_M1) && o_icb_rsp_err;
  assign m0_icb_rsp_rdata = (head == MST_M0) ? o_icb_rsp_rdata : '0;
  assign m1_icb_rsp_rdata = (head == MST_M1) ? o_icb_rsp_rdata : '0;

  assign rsp_hs = o_icb_rsp_valid && o_icb_rsp_ready;

  icb_arb_idfifo #(.DEPTH(OUTS_DEPTH)) u_idfifo (
    .clk       (clk),
    .rst       (rst),
    .push_i    (cmd_hs),
    .push_id_i (gnt),
    .pop_i     (rsp_hs),
    .head_o    (fifo_head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

endmodule

// File: tb/tb_icb_arb2.sv
// Directed + random bench for icb_arb2 against a queue-based reference model.
module tb_icb_arb2;

  localparam int AW = 32;
  localparam int DW = 64;
  localparam int MW = 8;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          mv[2], mrd[2], mrr[2];
  logic [AW-1:0] maddr[2];
  logic [DW-1:0] mwd[2];
  logic [MW-1:0] mwm[2];
  logic          cr[2], rv[2], rerr[2];
  logic [DW-1:0] rdat[2];

  logic          o_cv, o_cr, o_rd, o_rv, o_rr, o_err;
  logic [AW-1:0] o_addr;
  logic [DW-1:0] o_wd, o_rdata;
  logic [MW-1:0] o_wm;

  icb_arb2 #(.AW(AW), .DW(DW), .MW(MW), .OUTS_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .m0_icb_cmd_valid(mv[0]), .m0_icb_cmd_ready(cr[0]), .m0_icb_cmd_read(mrd[0]),
    .m0_icb_cmd_addr(maddr[0]), .m0_icb_cmd_wdata(mwd[0]), .m0_icb_cmd_wmask(mwm[0]),
    .m0_icb_rsp_valid(rv[0]), .m0_icb_rsp_ready(mrr[0]), .m0_icb_rsp_err(rerr[0]),
    .m0_icb_rsp_rdata(rdat[0]),
    .m1_icb_cmd_valid(mv[1]), .m1_icb_cmd_ready(cr[1]), .m1_icb_cmd_read(mrd[1]),
    .m1_icb_cmd_addr(maddr[1]), .m1_icb_cmd_wdata(mwd[1]), .m1_icb_cmd_wmask(mwm[1]),
    .m1_icb_rsp_valid(rv[1]), .m1_icb_rsp_ready(mrr[1]), .m1_icb_rsp_err(rerr[1]),
    .m1_icb_rsp_rdata(rdat[1]),
    .o_icb_cmd_valid(o_cv), .o_icb_cmd_ready(o_cr), .o_icb_cmd_read(o_rd),
    .o_icb_cmd_addr(o_addr), .o_icb_cmd_wdata(o_wd), .o_icb_cmd_wmask(o_wm),
    .o_icb_rsp_valid(o_rv), .o_icb_rsp_ready(o_rr), .o_icb_rsp_err(o_err),
    .o_icb_rsp_rdata(o_rdata)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: queue of issuing-master IDs, last winner, pending-command hold.
  int q[$];
  int last_g = 1;
  bit lck = 0;
  int lg = 0;
  bit acc[2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic model_step();
    int g, h;
    bit full, empty, ocv, orr;
    full  = (q.size() == DEPTH);
    empty = (q.size() == 0);
    if (lck)                g = lg;
    else if (mv[0] && mv[1]) g = (last_g == 1) ? 0 : 1;
    else if (mv[1])          g = 1;
    else                     g = 0;
    ocv = mv[g] && !full;
    chk("o_cmd_valid", o_cv, ocv);
    if (mv[0] || mv[1]) begin
      chk("m0_cmd_ready", cr[0], (g == 0) && o_cr && !full);
      chk("m1_cmd_ready", cr[1], (g == 1) && o_cr && !full);
    end
    if (ocv) begin
      chk("o_cmd_addr", o_addr, maddr[g]);
      chk("o_cmd_read", o_rd, mrd[g]);
      chk("o_cmd_wdata", o_wd, mwd[g]);
      chk("o_cmd_wmask", o_wm, mwm[g]);
    end
    h = empty ? 0 : q[0];
    orr = !empty && mrr[h];
    chk("o_rsp_ready", o_rr, orr);
    chk("m0_rsp_valid", rv[0], o_rv && !empty && (h == 0));
    chk("m1_rsp_valid", rv[1], o_rv && !empty && (h == 1));
    if (o_rv && !empty) begin
      chk("rsp_rdata", rdat[h], o_rdata);
      chk("rsp_err", rerr[h], o_err);
    end
    acc[0] = ocv && o_cr && (g == 0);
    acc[1] = ocv && o_cr && (g == 1);
    if (o_rv && orr) void'(q.pop_front());
    if (ocv && o_cr) begin
      q.push_back(g);
      last_g = g;
      lck = 0;
    end else begin
      lck = ocv;
      lg  = g;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cycle();
    settle();
    model_step();
  endtask

  task automatic set_cmd(input int m, input logic v, input logic rd, input logic [AW-1:0] a);
    mv[m] = v; mrd[m] = rd; maddr[m] = a;
    mwd[m] = {$urandom, $urandom}; mwm[m] = MW'($urandom);
  endtask

  task automatic drain();
    mv[0] = 0; mv[1] = 0; o_rv = 1; mrr[0] = 1; mrr[1] = 1;
    for (int i = 0; i < 20 && q.size() != 0; i++) begin
      o_rdata = {$urandom, $urandom};
      cycle();
    end
    if (q.size() != 0) begin
      miscompares++;
      $error("FAIL drain_timeout: observed %0d outstanding expected 0", q.size());
    end
    o_rv = 0;
  endtask

  initial begin
    for (int m = 0; m < 2; m++) begin
      set_cmd(m, 0, 0, '0); mrr[m] = 0; acc[m] = 0;
    end
    o_cr = 0; o_rv = 0; o_err = 0; o_rdata = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Reset state
    settle();
    chk("rst_cmd_valid", o_cv, 0);
    chk("rst_rsp_ready", o_rr, 0);
    chk("rst_m0_ready", cr[0], 0);
    chk("rst_m1_rsp_valid", rv[1], 0);
    model_step();
    rst = 1;

    // Ties after reset alternate m0, m1, m0
    o_cr = 1;
    set_cmd(0, 1, 1, 32'h100); set_cmd(1, 1, 1, 32'h200);
    settle(); chk("tie1_m0", cr[0], 1); model_step();
    set_cmd(0, 1, 1, 32'h104);
    settle(); chk("tie2_m1", cr[1], 1); model_step();
    set_cmd(1, 1, 1, 32'h204);
    settle(); chk("tie3_m0", cr[0], 1); model_step();
    drain();

    // Single master write with same-cycle pass-through, response to m0 only
    set_cmd(0, 1, 0, 32'h8000_0000); mwm[0] = 8'hFF; o_cr = 1;
    settle();
    chk("single_addr", o_addr, 32'h8000_0000);
    chk("single_wmask", o_wm, 8'hFF);
    model_step();
    mv[0] = 0; o_rv = 1; mrr[0] = 1; mrr[1] = 1; o_rdata = 64'hDEAD_BEEF;
    settle();
    chk("single_rsp_m0", rv[0], 1);
    chk("single_rsp_m1", rv[1], 0);
    model_step();
    o_rv = 0;

    // Tie held under ready=0: last winner was m0, so m1 wins and stays
    o_cr = 0;
    set_cmd(0, 1, 1, 32'h300); set_cmd(1, 1, 1, 32'h400);
    for (int i = 0; i < 5; i++) begin
      settle(); chk("lock_addr", o_addr, 32'h400); model_step();
    end
    o_cr = 1;
    cycle();
    mv[1] = 0;
    cycle();
    drain();

    // Lock overrides round-robin when the other master joins mid-wait
    o_cr = 1; set_cmd(1, 1, 1, 32'h500);
    cycle();
    o_cr = 0; set_cmd(1, 1, 1, 32'h504);
    cycle();
    set_cmd(0, 1, 1, 32'h600);
    settle(); chk("lock_rr_addr", o_addr, 32'h504); model_step();
    o_cr = 1;
    cycle();
    mv[1] = 0;
    cycle();
    drain();

    // FIFO full blocks the fifth command; a pop frees it one cycle later
    o_cr = 1;
    for (int i = 0; i < 4; i++) begin
      set_cmd(0, 1, 1, AW'(32'h700 + 4 * i));
      cycle();
    end
    set_cmd(0, 1, 1, 32'h710);
    settle(); chk("full_block", o_cv, 0); model_step();
    o_rv = 1; mrr[0] = 1;
    settle(); chk("full_no_bypass", o_cv, 0); model_step();
    o_rv = 0;
    settle(); chk("full_accept", cr[0], 1); model_step();
    drain();

    // Interleaved responses follow issue order m1, m0, m1
    o_cr = 1;
    set_cmd(1, 1, 1, 32'h900); cycle();
    mv[1] = 0; set_cmd(0, 1, 1, 32'h904); cycle();
    mv[0] = 0; set_cmd(1, 1, 1, 32'h908); cycle();
    mv[1] = 0;
    o_rv = 1; mrr[0] = 1; mrr[1] = 1; o_rdata = 64'h11;
    settle();
    chk("il_m1_valid", rv[1], 1);
    chk("il_m1_rdata", rdat[1], 64'h11);
    model_step();
    o_rdata = 64'h22; mrr[0] = 0;
    for (int i = 0; i < 3; i++) begin
      settle(); chk("il_hold_ready", o_rr, 0); model_step();
    end
    mrr[0] = 1;
    settle(); chk("il_m0_rdata", rdat[0], 64'h22); model_step();
    o_rdata = 64'h33;
    settle(); chk("il_m1_rdata2", rdat[1], 64'h33); model_step();
    o_rv = 0;

    // Randomized traffic; pending commands are held stable until accepted
    for (int n = 0; n < 500; n++) begin
      for (int m = 0; m < 2; m++) begin
        if (!mv[m] || acc[m])
          set_cmd(m, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), AW'($urandom));
        mrr[m] = ($urandom_range(0, 3) != 0);
      end
      o_cr    = ($urandom_range(0, 3) != 0);
      o_rv    = 1'($urandom_range(0, 1));
      o_err   = ($urandom_range(0, 7) == 0);
      o_rdata = {$urandom, $urandom};
      cycle();
    end
    drain();

    // Async reset with two outstanding commands
    o_cr = 1; o_err = 0;
    set_cmd(0, 1, 1, 32'hA00); cycle();
    set_cmd(0, 1, 1, 32'hA04); cycle();
    set_cmd(0, 1, 1, 32'hA08); o_rv = 1; mrr[0] = 1; mrr[1] = 1;
    #1 rst = 0;
    #1;
    chk("arst_cmd_valid", o_cv, 0);
    chk("arst_m0_ready", cr[0], 0);
    chk("arst_m0_rsp_valid", rv[0], 0);
    chk("arst_rsp_ready", o_rr, 0);
    q.delete(); last_g = 1; lck = 0; acc[0] = 0; acc[1] = 0;
    mv[0] = 0; mv[1] = 0;
    @(posedge clk); #1;
    rst = 1;
    settle(); chk("arst_empty_spurious", o_rr, 0); model_step();
    o_rv = 0;
    set_cmd(0, 1, 1, 32'hB00); set_cmd(1, 1, 1, 32'hC00);
    settle(); chk("arst_tie_m0", cr[0], 1); model_step();
    mv[0] = 0;
    cycle();
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
